dm_mem_ctrl: RTL and testbench
==============================

# dm_mem_ctrl

Memory-stage responder at the far end of the EX/DM pipeline latch. Consumes the registered address, store data and MemRead/MemWrt/Halt controls, runs a req/ack transaction on the data-memory port, stalls the pipeline until the access completes, and returns read data to writeback. Detects illegal accesses and terminates in a sticky halted state.

## Interface
Parameters:
- TIMEOUT, 64: max cycles waiting for mem_ack before a timeout error; legal range 2..255.

Ports (clk/rst: one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- EXDM_Addr  in  16  byte address (ALU result)
- EXDM_RTData  in  16  store data
- EXDM_MemRead  in  1  load request
- EXDM_MemWrt  in  1  store request
- EXDM_HaltSig  in  1  halt instruction present
- DM_ReadData  out  16  load data, valid while DM_Done=1 (held afterwards)
- DM_Done  out  1  one-cycle pulse: access completed
- DM_Stall  out  1  hold upstream latches
- DM_Halted  out  1  sticky halt
- DM_ErrCode  out  2  0 none, 1 misaligned, 2 read+write conflict, 3 timeout; sticky
- mem_req  out  1  memory request
- mem_wr  out  1  1=write, 0=read; stable while mem_req=1
- mem_addr  out  16  word-aligned address; stable while mem_req=1
- mem_wdata  out  16  write data; stable while mem_req=1
- mem_rdata  in  16  read data, sampled with mem_ack
- mem_ack  in  1  completion; ignored unless mem_req=1

## Operation
- States: IDLE, WAIT, DONE, HALTED.
- IDLE, priority order:
  - MemRead & MemWrt -> ErrCode=2, HALTED.
  - MemRead|MemWrt with Addr[0]=1 -> ErrCode=1, HALTED.
  - HaltSig (with or without mem op) -> HALTED, no access.
  - MemRead|MemWrt -> capture addr/wdata/wr, WAIT.
  - Otherwise stay IDLE.
- WAIT: mem_req=1. On mem_ack=1: capture mem_rdata (reads only; writes leave DM_ReadData unchanged), -> DONE. Timeout counter increments each WAIT cycle without ack; ack on the cycle the counter reaches TIMEOUT-1 still completes; otherwise ErrCode=3, mem_req drops, HALTED.
- DONE: DM_Done=1, DM_Stall=0; -> IDLE unconditionally. The upstream latch advances at this edge, so the request is never reissued.
- HALTED: DM_Stall=1, DM_Halted=1, mem_req=0; exit only by rst.
- DM_Stall = (IDLE & (MemRead|MemWrt|HaltSig)) | WAIT | HALTED (combinational from IDLE inputs).

## Timing
- Reset values: state IDLE, mem_req/mem_wr/DM_Done/DM_Halted=0, mem_addr/mem_wdata/DM_ReadData=0, DM_ErrCode=0, counter=0.
- Request seen in IDLE at cycle T -> mem_req=1 from T+1 (registered). Ack at cycle A -> DM_Done=1 and data valid at A+1. Minimum access = 3 cycles (IDLE, WAIT with ack, DONE); stall asserted for 2.
- Error/halt seen at T -> DM_Halted/ErrCode visible at T+1; DM_Stall already high at T.
- rst during WAIT: mem_req=0 the cycle after the reset edge; a late mem_ack is ignored.
- mem_ack while mem_req=0: ignored, no state change.

## Structure
- Package dm_pkg: state enum (IDLE, WAIT, DONE, HALTED), ErrCode constants (ERR_NONE, ERR_ALIGN, ERR_CONFLICT, ERR_TIMEOUT).
- Sub-module dm_timeout_ctr: clear/enable counter with terminal-count flag; width 8.
- Capture registers use the existing register/dff cells with write enables.

## Test plan
- Read: Addr=0x0010, MemRead=1, ack 2 cycles after mem_req, mem_rdata=0xBEEF -> mem_req high 3 cycles, mem_wr=0, DM_Done one cycle, DM_ReadData=0xBEEF, ErrCode=0.
- Write: Addr=0x0022, RTData=0x1234, MemWrt=1, same-cycle ack -> mem_wr=1, mem_addr=0x0022, mem_wdata=0x1234 for one cycle; DM_ReadData unchanged.
- Back-to-back reads 0x0002 then 0x0004, ack immediately -> two DM_Done pulses separated by 2 cycles; no duplicate mem_req.
- Misaligned Addr=0x0003 MemRead=1 -> no mem_req, ErrCode=1, DM_Halted=1 stays after inputs clear; same with MemRead=MemWrt=1 -> ErrCode=2.
- No ack, TIMEOUT=4 -> mem_req high exactly 4 cycles, then ErrCode=3, DM_Halted=1; ack on 4th cycle instead -> normal DONE.
- rst asserted mid-WAIT then ack -> all outputs at reset values; HaltSig=1 alone -> DM_Halted=1, no mem_req, DM_Stall high until rst.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the memory-stage responder.
package dm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone,
    StHalted
  } dm_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ALIGN    = 2'd1;
  localparam logic [1:0] ERR_CONFLICT = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam int unsigned CtrWidth = 8;

endpackage

// File: rtl/dm_timeout_ctr.sv
// Clear/enable up-counter that saturates at Terminal and flags it.
module dm_timeout_ctr #(
  parameter int unsigned          Width    = 8,
  parameter logic [Width-1:0]     Terminal = '1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == Terminal);

endmodule

// File: rtl/dm_mem_ctrl.sv
// Memory-stage responder: runs one req/ack access per EX/DM instruction, stalls
// upstream until it completes, and parks in a sticky halted state on errors.
module dm_mem_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] EXDM_Addr,
  input  logic [15:0] EXDM_RTData,
  input  logic        EXDM_MemRead,
  input  logic        EXDM_MemWrt,
  input  logic        EXDM_HaltSig,
  output logic [15:0] DM_ReadData,
  output logic        DM_Done,
  output logic        DM_Stall,
  output logic        DM_Halted,
  output logic [1:0]  DM_ErrCode,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  dm_state_e   state_q, state_d;
  logic [1:0]  err_q, err_d;
  logic        wr_q;
  logic [15:0] addr_q, wdata_q, rdata_q;
  logic        cap_en, rdata_en;
  logic        ctr_clr, ctr_en, ctr_tc;
  logic        mem_op;

  assign mem_op = EXDM_MemRead | EXDM_MemWrt;

  dm_timeout_ctr #(
    .Width    (CtrWidth),
    .Terminal (CtrWidth'(TIMEOUT - 1))
  ) u_timeout_ctr (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (ctr_clr),
    .en_i  (ctr_en),
    .tc_o  (ctr_tc)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    cap_en   = 1'b0;
    rdata_en = 1'b0;
    ctr_clr  = 1'b0;
    ctr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ctr_clr = 1'b1;
        if (EXDM_MemRead && EXDM_MemWrt) begin
          err_d   = ERR_CONFLICT;
          state_d = StHalted;
        end else if (mem_op && EXDM_Addr[0]) begin
          err_d   = ERR_ALIGN;
          state_d = StHalted;
        end else if (EXDM_HaltSig) begin
          state_d = StHalted;
        end else if (mem_op) begin
          cap_en  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_ack) begin
          rdata_en = !wr_q;
          state_d  = StDone;
        end else if (ctr_tc) begin
          err_d   = ERR_TIMEOUT;
          state_d = StHalted;
        end else begin
          ctr_en = 1'b1;
        end
      end
      // Upstream latch advances on this edge, so the request is never reissued.
      StDone:   state_d = StIdle;
      StHalted: state_d = StHalted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= ERR_NONE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (cap_en) begin
        wr_q    <= EXDM_MemWrt;
        addr_q  <= EXDM_Addr;
        wdata_q <= EXDM_RTData;
      end
      if (rdata_en) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_req     = (state_q == StWait);
  assign mem_wr      = wr_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign DM_ReadData = rdata_q;
  assign DM_Done     = (state_q == StDone);
  assign DM_Halted   = (state_q == StHalted);
  assign DM_ErrCode  = err_q;
  assign DM_Stall    = ((state_q == StIdle) && (mem_op || EXDM_HaltSig)) ||
                       (state_q == StWait) || (state_q == StHalted);

endmodule

// File: tb/tb_dm_mem_ctrl.sv
// Scoreboard bench for dm_mem_ctrl: pipeline driver, memory responder, monitor.
module tb_dm_mem_ctrl;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] EXDM_Addr = '0, EXDM_RTData = '0;
  logic        EXDM_MemRead = 1'b0, EXDM_MemWrt = 1'b0, EXDM_HaltSig = 1'b0;
  logic [15:0] DM_ReadData, mem_addr, mem_wdata;
  logic        DM_Done, DM_Stall, DM_Halted, mem_req, mem_wr;
  logic [1:0]  DM_ErrCode;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack;

  dm_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .EXDM_Addr    (EXDM_Addr),
    .EXDM_RTData  (EXDM_RTData),
    .EXDM_MemRead (EXDM_MemRead),
    .EXDM_MemWrt  (EXDM_MemWrt),
    .EXDM_HaltSig (EXDM_HaltSig),
    .DM_ReadData  (DM_ReadData),
    .DM_Done      (DM_Done),
    .DM_Stall     (DM_Stall),
    .DM_Halted    (DM_Halted),
    .DM_ErrCode   (DM_ErrCode),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int unsigned len;
  } req_t;

  req_t        req_q[$];
  int unsigned delay_q[$];
  logic [15:0] done_q[$];
  logic [1:0]  err_q[$];
  int          done_t[$];

  logic [15:0] ref_mem[256];
  logic [15:0] dev_mem[256];
  logic [15:0] last_rd = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not expected by scoreboard (cycle %0d)", name, cyc);
  endtask

  // Memory responder: acks after a per-request delay taken from delay_q.
  logic        auto_ack = 1'b0, man_ack = 1'b0, resp_en = 1'b1, busy = 1'b0;
  int unsigned wcnt = 0;
  assign mem_ack = resp_en ? auto_ack : man_ack;

  always @(posedge clk) begin
    #1;
    auto_ack  = 1'b0;
    mem_rdata = 16'($urandom);
    if (rst || !mem_req) begin
      busy = 1'b0;
    end else begin
      if (!busy) begin
        busy = 1'b1;
        wcnt = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
      end
      if (wcnt == 0) begin
        auto_ack = 1'b1;
        if (mem_wr) dev_mem[mem_addr[8:1]] = mem_wdata;
        else mem_rdata = dev_mem[mem_addr[8:1]];
      end else begin
        wcnt--;
      end
    end
  end

  // Monitor: checks requests, completions and halts against the queues.
  int   req_len = 0;
  logic halted_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      req_len     = 0;
      halted_prev = 1'b0;
    end else begin
      if (mem_req) begin
        if (req_q.size() == 0) begin
          if (req_len == 0) fail("unexpected_mem_req");
        end else begin
          check("mem_wr", mem_wr, req_q[0].wr);
          check("mem_addr", mem_addr, req_q[0].addr);
          check("mem_wdata", mem_wdata, req_q[0].wdata);
        end
        req_len++;
      end else if (req_len != 0) begin
        if (req_q.size() > 0) begin
          check("mem_req_len", req_len, req_q[0].len);
          void'(req_q.pop_front());
        end
        req_len = 0;
      end
      if (DM_Done) begin
        done_t.push_back(cyc);
        check("stall_in_done", DM_Stall, 1'b0);
        if (done_q.size() == 0) fail("unexpected_done");
        else check("read_data", DM_ReadData, done_q.pop_front());
      end
      if (DM_Halted && !halted_prev) begin
        if (err_q.size() == 0) fail("unexpected_halt");
        else check("err_code", DM_ErrCode, err_q.pop_front());
      end
      halted_prev = DM_Halted;
    end
  end

  task automatic clear_inputs();
    EXDM_Addr    = '0;
    EXDM_RTData  = '0;
    EXDM_MemRead = 1'b0;
    EXDM_MemWrt  = 1'b0;
    EXDM_HaltSig = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    resp_en = 1'b1;
    man_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_q.delete();
    delay_q.delete();
    done_q.delete();
    err_q.delete();
    last_rd = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_mem_wr"}, mem_wr, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 16'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 16'h0);
    check({tag, "_read_data"}, DM_ReadData, 16'h0);
    check({tag, "_done"}, DM_Done, 1'b0);
    check({tag, "_halted"}, DM_Halted, 1'b0);
    check({tag, "_err"}, DM_ErrCode, 2'd0);
    check({tag, "_stall"}, DM_Stall, 1'b0);
  endtask

  // Present one instruction and hold it until the pipeline is allowed to advance.
  task automatic do_op(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] data, input int unsigned dly);
    int   n = 0;
    logic s;
    if (rd || wr) begin
      req_q.push_back(req_t'{wr, addr, data, dly + 1});
      delay_q.push_back(dly);
      if (rd) last_rd = ref_mem[addr[8:1]];
      else ref_mem[addr[8:1]] = data;
      done_q.push_back(last_rd);
    end
    EXDM_MemRead = rd;
    EXDM_MemWrt  = wr;
    EXDM_Addr    = addr;
    EXDM_RTData  = data;
    do begin
      @(negedge clk);
      s = DM_Stall;
      @(posedge clk);
      n++;
    end while (s && n < 40);
    if (s) fail("op_never_completed");
    #1;
    clear_inputs();
  endtask

  task automatic err_op(input logic rd, input logic wr, input logic halt,
                        input logic [15:0] addr, input logic [1:0] exp);
    err_q.push_back(exp);
    EXDM_MemRead = rd;
    EXDM_MemWrt  = wr;
    EXDM_HaltSig = halt;
    EXDM_Addr    = addr;
    EXDM_RTData  = 16'hA5A5;
    @(negedge clk);
    check("stall_before_halt", DM_Stall, 1'b1);
    check("not_halted_yet", DM_Halted, 1'b0);
    @(posedge clk);
    #1;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("halted_sticky", DM_Halted, 1'b1);
    check("stall_while_halted", DM_Stall, 1'b1);
    check("err_sticky", DM_ErrCode, exp);
    check("halt_observed", err_q.size(), 0);
    do_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[8] = 16'hBEEF;
    dev_mem[8] = 16'hBEEF;

    do_reset();
    check_reset_vals("reset");

    // Directed: read with 2-cycle ack delay, same-cycle write, back-to-back reads.
    do_op(1'b1, 1'b0, 16'h0010, 16'h0000, 2);
    do_op(1'b0, 1'b1, 16'h0022, 16'h1234, 0);
    done_t.delete();
    do_op(1'b1, 1'b0, 16'h0002, 16'h0000, 0);
    do_op(1'b1, 1'b0, 16'h0004, 16'h0000, 0);
    check("b2b_done_count", done_t.size(), 2);
    if (done_t.size() == 2) check("b2b_done_spacing", done_t[1] - done_t[0], 3);
    // Ack on the last legal cycle still completes.
    do_op(1'b1, 1'b0, 16'h0022, 16'h0000, TIMEOUT - 1);

    for (int i = 0; i < 150; i++) begin
      int unsigned kind = $urandom_range(0, 9);
      logic [15:0] a    = 16'($urandom) & 16'hFFFE;
      do_op(kind inside {[2:5]}, kind >= 6, a, 16'($urandom), $urandom_range(0, TIMEOUT - 1));
    end

    // Timeout: no ack at all.
    req_q.push_back(req_t'{1'b0, 16'h0040, 16'h0777, TIMEOUT});
    delay_q.push_back(255);
    err_q.push_back(2'd3);
    EXDM_MemRead = 1'b1;
    EXDM_Addr    = 16'h0040;
    EXDM_RTData  = 16'h0777;
    n = 0;
    while (!DM_Halted && n < 30) begin
      @(negedge clk);
      n++;
    end
    clear_inputs();
    repeat (2) @(negedge clk);
    check("timeout_halted", DM_Halted, 1'b1);
    check("timeout_err", DM_ErrCode, 2'd3);
    check("timeout_req_seen", req_q.size(), 0);
    check("timeout_halt_seen", err_q.size(), 0);
    do_reset();

    err_op(1'b1, 1'b0, 1'b0, 16'h0003, 2'd1);
    err_op(1'b0, 1'b1, 1'b0, 16'h0101, 2'd1);
    err_op(1'b1, 1'b1, 1'b0, 16'h0008, 2'd2);
    err_op(1'b1, 1'b1, 1'b0, 16'h0005, 2'd2);
    err_op(1'b0, 1'b0, 1'b1, 16'h0000, 2'd0);
    err_op(1'b1, 1'b0, 1'b1, 16'h0010, 2'd0);

    // Reset in the middle of a wait, then a late ack.
    last_rd = ref_mem[8];
    do_op(1'b1, 1'b0, 16'h0010, 16'h0000, 1);
    resp_en = 1'b0;
    req_q.push_back(req_t'{1'b0, 16'h0050, 16'h0000, 99});
    EXDM_MemRead = 1'b1;
    EXDM_Addr    = 16'h0050;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_q.delete();
    delay_q.delete();
    done_q.delete();
    last_rd = '0;
    man_ack = 1'b1;
    check_reset_vals("rst_mid_wait");
    check_reset_vals("late_ack");
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    resp_en = 1'b1;

    do_op(1'b1, 1'b0, 16'h0010, 16'h0000, 0);
    repeat (2) @(negedge clk);
    check("left_req", req_q.size(), 0);
    check("left_done", done_q.size(), 0);
    check("left_err", err_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
